// File: rtl/audio_out_pkg.sv
// Shared types and constants for the audio output stage (gain ramp + delta-sigma DAC).
package audio_out_pkg;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        PLAY      = 2'd2,
        RAMP_DOWN = 2'd3
    } gain_state_e;

    localparam logic [8:0]  GAIN_UNITY = 9'd256;
    localparam logic [15:0] MIDSCALE   = 16'h8000;

    // Second-order modulator integrator widths
    localparam int I1_W = 20;
    localparam int I2_W = 24;

    // Gain increment that clips at unity instead of overshooting
    function automatic logic [8:0] gain_inc(input logic [8:0] g, input logic [8:0] step);
        logic [9:0] sum;
        sum = {1'b0, g} + {1'b0, step};
        return (sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : sum[8:0];
    endfunction

    // Gain decrement that clips at zero instead of wrapping
    function automatic logic [8:0] gain_dec(input logic [8:0] g, input logic [8:0] step);
        return (g <= step) ? 9'd0 : (g - step);
    endfunction

endpackage

// File: rtl/dsm_mod.sv
// Delta-sigma modulator core: advances one step per strobe and drives the 1-bit stream.
// Build option: DSM_ORDER2_EN selects a saturating second-order loop; when undefined
// the modulator is a first-order carry accumulator on the offset-binary sample.
module dsm_mod
    import audio_out_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        strobe_i,
    input  logic [15:0] scaled_i,
    output logic        pdm_o
);

`ifdef DSM_ORDER2_EN

    // Two guard bits let each sum be formed exactly before it is clipped
    localparam int S1_W = I1_W + 2;
    localparam int S2_W = I2_W + 2;

    localparam logic signed [S1_W-1:0] I1_HI = {3'b000, {(I1_W-1){1'b1}}};
    localparam logic signed [S1_W-1:0] I1_LO = {3'b111, {(I1_W-1){1'b0}}};
    localparam logic signed [S2_W-1:0] I2_HI = {3'b000, {(I2_W-1){1'b1}}};
    localparam logic signed [S2_W-1:0] I2_LO = {3'b111, {(I2_W-1){1'b0}}};

    logic signed [I1_W-1:0] i1;
    logic signed [I2_W-1:0] i2;
    logic signed [I1_W-1:0] i1_nx;
    logic signed [I2_W-1:0] i2_nx;
    logic signed [S1_W-1:0] i1_sum;
    logic signed [S2_W-1:0] i2_sum;
    logic signed [16:0]     fb;
    logic signed [15:0]     scaled_s;

    assign scaled_s = $signed(scaled_i);
    // Feedback is the full-scale value the previous output bit represents
    assign fb       = pdm_o ? 17'sd32767 : -17'sd32768;

    // Next integrator values, each clipped to its own register range
    always_comb begin
        i1_sum = S1_W'(i1) + S1_W'(scaled_s) - S1_W'(fb);
        if (i1_sum > I1_HI) begin
            i1_nx = I1_W'(I1_HI);
        end else if (i1_sum < I1_LO) begin
            i1_nx = I1_W'(I1_LO);
        end else begin
            i1_nx = i1_sum[I1_W-1:0];
        end

        i2_sum = S2_W'(i2) + S2_W'(i1_nx) - S2_W'(fb);
        if (i2_sum > I2_HI) begin
            i2_nx = I2_W'(I2_HI);
        end else if (i2_sum < I2_LO) begin
            i2_nx = I2_W'(I2_LO);
        end else begin
            i2_nx = i2_sum[I2_W-1:0];
        end
    end

    // Integrators and output bit advance together on each strobe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i1    <= '0;
            i2    <= '0;
            pdm_o <= 1'b0;
        end else if (strobe_i) begin
            i1    <= i1_nx;
            i2    <= i2_nx;
            pdm_o <= ~i2_nx[I2_W-1];
        end
    end

`else

    logic [15:0] acc;
    logic [16:0] acc_sum;

    // Offset binary maps -32768..32767 onto 0..65535, so carry density tracks the sample
    assign acc_sum = {1'b0, acc} + {1'b0, scaled_i ^ MIDSCALE};

    // Accumulator wraps freely; the carry out is the output bit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc   <= '0;
            pdm_o <= 1'b0;
        end else if (strobe_i) begin
            acc   <= acc_sum[15:0];
            pdm_o <= acc_sum[16];
        end
    end

`endif

endmodule

// File: rtl/audio_dsm_dac.sv
// Audio output stage: latches each mix sample, applies a click-free mute/unmute gain
// ramp and converts the result to a 1-bit PDM stream for an external RC filter.
// Build option: DSM_ORDER2_EN switches the modulator to second order (see dsm_mod).
//
// state     | meaning
// ----------+------------------------------------------------
// MUTED     | gain held at 0, output is a midscale 0101 stream
// RAMP_UP   | gain climbs by RAMP_STEP per accepted sample
// PLAY      | gain held at unity (256)
// RAMP_DOWN | gain falls by RAMP_STEP per accepted sample
module audio_dsm_dac
    import audio_out_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int RAMP_STEP = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic [15:0] audio_i,
    input  logic        audio_valid_i,
    output logic        pdm_o,
    output logic        muted_o
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [8:0] STEP     = 9'(RAMP_STEP);

    gain_state_e        state;
    logic [8:0]         gain_q;
    logic [8:0]         gain_up;
    logic [8:0]         gain_dn;
    logic [15:0]        scaled_q;
    logic [15:0]        scaled_nx;
    logic signed [23:0] prod;
    logic [7:0]         div_cnt;
    logic               strobe;

    assign strobe  = (div_cnt == DIV_LAST);
    assign gain_up = gain_inc(gain_q, STEP);
    assign gain_dn = gain_dec(gain_q, STEP);

    // |audio * gain| <= 2^23 because gain never exceeds unity, so 24 bits hold it exactly
    assign prod      = 24'($signed(audio_i)) * 24'($signed({1'b0, gain_q}));
    assign scaled_nx = 16'(prod >>> 8);

    // Free-running divider; the modulator steps on its terminal count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt <= '0;
        end else if (strobe) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // Sample latch: scale by the gain in force before this sample's update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scaled_q <= '0;
        end else if (audio_valid_i) begin
            scaled_q <= scaled_nx;
        end
    end

    // Gain FSM: moves only on accepted samples; a reversal holds the gain for that sample
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= MUTED;
            gain_q  <= '0;
            muted_o <= 1'b1;
        end else if (audio_valid_i) begin
            case (state)
                MUTED: begin
                    if (enable_i) begin
                        gain_q  <= gain_up;
                        state   <= (gain_up == GAIN_UNITY) ? PLAY : RAMP_UP;
                        muted_o <= 1'b0;
                    end
                end
                RAMP_UP: begin
                    if (!enable_i) begin
                        state <= RAMP_DOWN;
                    end else begin
                        gain_q <= gain_up;
                        if (gain_up == GAIN_UNITY) begin
                            state <= PLAY;
                        end
                    end
                end
                PLAY: begin
                    if (!enable_i) begin
                        gain_q <= gain_dn;
                        if (gain_dn == 9'd0) begin
                            state   <= MUTED;
                            muted_o <= 1'b1;
                        end else begin
                            state <= RAMP_DOWN;
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (enable_i) begin
                        state <= RAMP_UP;
                    end else begin
                        gain_q <= gain_dn;
                        if (gain_dn == 9'd0) begin
                            state   <= MUTED;
                            muted_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= MUTED;
                    gain_q  <= '0;
                    muted_o <= 1'b1;
                end
            endcase
        end
    end

    dsm_mod u_dsm_mod (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .strobe_i (strobe),
        .scaled_i (scaled_q),
        .pdm_o    (pdm_o)
    );

endmodule

// File: tb/tb_audio_dsm_dac.sv
// Bench for audio_dsm_dac: one instance at CLK_DIV=1 for long-window density checks,
// one at CLK_DIV=4 for strobe timing. Both share the same stimulus.
module tb_audio_dsm_dac;
    import audio_out_pkg::*;

    localparam int STEP = 1;

    typedef struct packed {
        logic [15:0] scaled;
        logic        muted;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] audio = 16'h0000;
    logic        pdm1, muted1, pdm4, muted4;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int          m_gain;
    gain_state_e m_state;
    logic [15:0] m_scaled;
    logic [15:0] m1_acc, m4_acc;
    logic        m1_pdm, m4_pdm;
    int          m4_div;
    exp_t        q[$];

    audio_dsm_dac #(.CLK_DIV(1), .RAMP_STEP(STEP)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .audio_i(audio),
        .audio_valid_i(valid), .pdm_o(pdm1), .muted_o(muted1)
    );

    audio_dsm_dac #(.CLK_DIV(4), .RAMP_STEP(STEP)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .audio_i(audio),
        .audio_valid_i(valid), .pdm_o(pdm4), .muted_o(muted4)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        m_gain = 0; m_state = MUTED; m_scaled = 16'h0000;
        m1_acc = 16'h0000; m4_acc = 16'h0000; m1_pdm = 1'b0; m4_pdm = 1'b0; m4_div = 0;
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // One clock of stimulus; the model predicts what the coming edge produces
    task automatic step(input logic v, input logic en, input logic [15:0] aud);
        logic [16:0] s;
        exp_t        e;
        int          prod;
        @(negedge clk);
        valid = v; enable = en; audio = aud;
        s = {1'b0, m1_acc} + {1'b0, m_scaled ^ 16'h8000};
        m1_acc = s[15:0]; m1_pdm = s[16];
        if (m4_div == 3) begin
            s = {1'b0, m4_acc} + {1'b0, m_scaled ^ 16'h8000};
            m4_acc = s[15:0]; m4_pdm = s[16];
        end
        m4_div = (m4_div == 3) ? 0 : m4_div + 1;
        if (v) begin
            prod = int'($signed(aud)) * m_gain;
            e.scaled = 16'(prod >>> 8);
            case (m_state)
                MUTED: if (en) begin
                    m_gain = (m_gain + STEP > 256) ? 256 : m_gain + STEP;
                    m_state = (m_gain == 256) ? PLAY : RAMP_UP;
                end
                RAMP_UP: if (!en) m_state = RAMP_DOWN;
                    else begin
                        m_gain = (m_gain + STEP > 256) ? 256 : m_gain + STEP;
                        if (m_gain == 256) m_state = PLAY;
                    end
                PLAY: if (!en) begin
                    m_gain = (m_gain < STEP) ? 0 : m_gain - STEP;
                    m_state = (m_gain == 0) ? MUTED : RAMP_DOWN;
                end
                default: if (en) m_state = RAMP_UP;
                    else begin
                        m_gain = (m_gain < STEP) ? 0 : m_gain - STEP;
                        if (m_gain == 0) m_state = MUTED;
                    end
            endcase
            e.muted = (m_state == MUTED);
            m_scaled = e.scaled;
            q.push_back(e);
        end
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (muted1 !== 1'b1) $display("FAIL reset_muted: got %b want 1", muted1); else n_pass++;
        n_checks++; if (pdm1 !== 1'b0) $display("FAIL reset_pdm: got %b want 0", pdm1); else n_pass++;
        n_checks++; if (dut.scaled_q !== 16'h0000) $display("FAIL reset_scaled: got %h want 0000", dut.scaled_q); else n_pass++;
        n_checks++; if (dut.state !== MUTED) $display("FAIL reset_state: got %0d want MUTED", dut.state); else n_pass++;
        n_checks++; if (muted4 !== 1'b1) $display("FAIL reset_muted4: got %b want 1", muted4); else n_pass++;
    endtask

    task automatic test_muted_pattern();
        exp_t e;
        logic want;
        for (int i = 0; i < 8; i++) begin
            step((i % 2) == 0, 1'b0, 16'h7FFF);
            if ((i % 2) == 0) begin
                e = q.pop_front();
                n_checks++; if (dut.scaled_q !== e.scaled) $display("FAIL muted_scaled: got %h want %h", dut.scaled_q, e.scaled); else n_pass++;
                n_checks++; if (muted1 !== e.muted) $display("FAIL muted_flag: got %b want %b", muted1, e.muted); else n_pass++;
            end
`ifndef DSM_ORDER2_EN
            want = ((i % 2) == 1);
            n_checks++; if (pdm1 !== want) $display("FAIL muted_pdm[%0d]: got %b want %b", i, pdm1, want); else n_pass++;
`endif
        end
    endtask

    task automatic test_ramp_to_play();
        exp_t e;
        for (int i = 1; i <= 256; i++) begin
            step(1'b1, 1'b1, 16'h4000);
            e = q.pop_front();
            n_checks++; if (dut.scaled_q !== e.scaled) $display("FAIL ramp_scaled[%0d]: got %h want %h", i, dut.scaled_q, e.scaled); else n_pass++;
            n_checks++; if (muted1 !== e.muted) $display("FAIL ramp_muted[%0d]: got %b want %b", i, muted1, e.muted); else n_pass++;
`ifndef DSM_ORDER2_EN
            n_checks++; if (pdm1 !== m1_pdm) $display("FAIL ramp_pdm1[%0d]: got %b want %b", i, pdm1, m1_pdm); else n_pass++;
            n_checks++; if (pdm4 !== m4_pdm) $display("FAIL ramp_pdm4[%0d]: got %b want %b", i, pdm4, m4_pdm); else n_pass++;
`endif
            if (i == 1) begin
                n_checks++; if (muted1 !== 1'b0) $display("FAIL ramp_unmute_first: got %b want 0", muted1); else n_pass++;
            end
            if (i == 255) begin
                n_checks++; if (dut.state !== RAMP_UP) $display("FAIL ramp_state_255: got %0d want RAMP_UP", dut.state); else n_pass++;
            end
            if (i == 256) begin
                n_checks++; if (dut.state !== PLAY) $display("FAIL ramp_state_256: got %0d want PLAY", dut.state); else n_pass++;
            end
            step(1'b0, 1'b1, 16'h4000);
        end
    endtask

    task automatic test_full_scale();
        exp_t e;
        int   ones;
        step(1'b1, 1'b1, 16'h7FFF);
        e = q.pop_front();
        n_checks++; if (dut.scaled_q !== 16'h7FFF) $display("FAIL fs_pos_scaled: got %h want 7fff", dut.scaled_q); else n_pass++;
        ones = 0;
        for (int i = 0; i < 65536; i++) begin
            step(1'b0, 1'b1, 16'h7FFF);
            ones += int'(pdm1);
        end
`ifdef DSM_ORDER2_EN
        n_checks++; if (ones < 65535 - 65 || ones > 65535) $display("FAIL fs_pos_density: got %0d want 65535 +-65", ones); else n_pass++;
`else
        n_checks++; if (ones != 65535) $display("FAIL fs_pos_ones: got %0d want 65535", ones); else n_pass++;
`endif
        step(1'b1, 1'b1, 16'h8000);
        e = q.pop_front();
        n_checks++; if (dut.scaled_q !== e.scaled) $display("FAIL fs_neg_scaled: got %h want %h", dut.scaled_q, e.scaled); else n_pass++;
`ifdef DSM_ORDER2_EN
        for (int i = 0; i < 4096; i++) step(1'b0, 1'b1, 16'h8000);
`endif
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            step(1'b0, 1'b1, 16'h8000);
            ones += int'(pdm1);
        end
        n_checks++; if (ones != 0) $display("FAIL fs_neg_ones: got %0d want 0", ones); else n_pass++;
    endtask

    task automatic test_strobe_timing();
        logic prev;
        logic want;
        do_reset();
        prev = pdm4;
        want = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            step(1'b0, 1'b0, 16'h0000);
            if ((e % 4) != 0) begin
                n_checks++; if (pdm4 !== prev) $display("FAIL strobe_hold[%0d]: got %b want %b", e, pdm4, prev); else n_pass++;
            end
`ifndef DSM_ORDER2_EN
            if ((e % 4) == 0) want = (((e / 4) % 2) == 0);
            n_checks++; if (pdm4 !== want) $display("FAIL strobe_value[%0d]: got %b want %b", e, pdm4, want); else n_pass++;
`endif
            prev = pdm4;
        end
    endtask

    task automatic test_coincident();
        exp_t e;
        for (int i = 0; i < 257; i++) begin
            step(1'b1, 1'b1, 16'h8000);
            e = q.pop_front();
            n_checks++; if (dut4.scaled_q !== e.scaled) $display("FAIL coin_ramp_scaled[%0d]: got %h want %h", i, dut4.scaled_q, e.scaled); else n_pass++;
            step(1'b0, 1'b1, 16'h8000);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h8000);
        while (m4_div != 3) step(1'b0, 1'b1, 16'h8000);
        step(1'b1, 1'b1, 16'h7FFF);
        e = q.pop_front();
        n_checks++; if (dut4.scaled_q !== 16'h7FFF) $display("FAIL coin_scaled: got %h want 7fff", dut4.scaled_q); else n_pass++;
`ifndef DSM_ORDER2_EN
        n_checks++; if (pdm4 !== 1'b0) $display("FAIL coin_old_sample: got %b want 0", pdm4); else n_pass++;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h7FFF);
        n_checks++; if (pdm4 !== m4_pdm) $display("FAIL coin_new_sample: got %b want %b", pdm4, m4_pdm); else n_pass++;
`endif
    endtask

    task automatic test_ramp_down();
        exp_t e;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1, 16'h4000);
            e = q.pop_front();
            n_checks++; if (dut.scaled_q !== e.scaled) $display("FAIL rd_up_scaled[%0d]: got %h want %h", i, dut.scaled_q, e.scaled); else n_pass++;
            step(1'b0, 1'b1, 16'h4000);
        end
        step(1'b1, 1'b0, 16'h4000);
        e = q.pop_front();
        n_checks++; if (dut.gain_q !== 9'd100) $display("FAIL rd_reverse_gain: got %0d want 100", dut.gain_q); else n_pass++;
        n_checks++; if (dut.state !== RAMP_DOWN) $display("FAIL rd_reverse_state: got %0d want RAMP_DOWN", dut.state); else n_pass++;
        for (int i = 1; i <= 100; i++) begin
            step(1'b1, 1'b0, 16'h4000);
            e = q.pop_front();
            n_checks++; if (dut.scaled_q !== e.scaled) $display("FAIL rd_scaled[%0d]: got %h want %h", i, dut.scaled_q, e.scaled); else n_pass++;
            n_checks++; if (muted1 !== e.muted) $display("FAIL rd_muted[%0d]: got %b want %b", i, muted1, e.muted); else n_pass++;
            if (i == 99) begin
                n_checks++; if (muted1 !== 1'b0) $display("FAIL rd_not_muted_99: got %b want 0", muted1); else n_pass++;
            end
            if (i == 100) begin
                n_checks++; if (muted1 !== 1'b1) $display("FAIL rd_muted_100: got %b want 1", muted1); else n_pass++;
                n_checks++; if (dut.gain_q !== 9'd0) $display("FAIL rd_gain_100: got %0d want 0", dut.gain_q); else n_pass++;
            end
            step(1'b0, 1'b0, 16'h4000);
        end
    endtask

    task automatic test_gain128();
        exp_t e;
        do_reset();
        for (int i = 0; i < 128; i++) begin
            step(1'b1, 1'b1, 16'h4000);
            e = q.pop_front();
            step(1'b0, 1'b1, 16'h4000);
        end
        step(1'b1, 1'b0, 16'h4000);
        e = q.pop_front();
        n_checks++; if (dut.scaled_q !== 16'h2000) $display("FAIL g128_pos: got %h want 2000", dut.scaled_q); else n_pass++;
        step(1'b1, 1'b1, 16'hC000);
        e = q.pop_front();
        n_checks++; if (dut.scaled_q !== 16'hE000) $display("FAIL g128_neg: got %h want e000", dut.scaled_q); else n_pass++;
        n_checks++; if (dut.state !== RAMP_UP) $display("FAIL g128_state: got %0d want RAMP_UP", dut.state); else n_pass++;
        n_checks++; if (dut.gain_q !== 9'd128) $display("FAIL g128_gain: got %0d want 128", dut.gain_q); else n_pass++;
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 16'h6000);
            e = q.pop_front();
            step(1'b0, 1'b1, 16'h6000);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (muted1 !== 1'b1) $display("FAIL ar_muted: got %b want 1", muted1); else n_pass++;
        n_checks++; if (pdm1 !== 1'b0) $display("FAIL ar_pdm: got %b want 0", pdm1); else n_pass++;
        n_checks++; if (dut.state !== MUTED) $display("FAIL ar_state: got %0d want MUTED", dut.state); else n_pass++;
        n_checks++; if (dut.gain_q !== 9'd0) $display("FAIL ar_gain: got %0d want 0", dut.gain_q); else n_pass++;
        n_checks++; if (dut.scaled_q !== 16'h0000) $display("FAIL ar_scaled: got %h want 0000", dut.scaled_q); else n_pass++;
        n_checks++; if (dut4.div_cnt !== 8'd0) $display("FAIL ar_div: got %0d want 0", dut4.div_cnt); else n_pass++;
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 16'h6000);
            e = q.pop_front();
            n_checks++; if (dut.scaled_q !== e.scaled) $display("FAIL ar_resume_scaled[%0d]: got %h want %h", i, dut.scaled_q, e.scaled); else n_pass++;
            n_checks++; if (muted1 !== e.muted) $display("FAIL ar_resume_muted[%0d]: got %b want %b", i, muted1, e.muted); else n_pass++;
            step(1'b0, 1'b1, 16'h6000);
        end
        n_checks++; if (dut.gain_q !== 9'd10) $display("FAIL ar_resume_gain: got %0d want 10", dut.gain_q); else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_muted_pattern();
        test_ramp_to_play();
        test_full_scale();
        test_strobe_timing();
        test_coincident();
        test_ramp_down();
        test_gain128();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
